// File: rtl/slot_desc_mgr.sv
// Packet slot descriptor manager: tracks free slots per core and hands out
// one descriptor at a time, rotating fairly across enabled cores.
module slot_desc_mgr #(
    parameter int CORE_COUNT = 4,
    parameter int SLOT_COUNT = 16,
    parameter int ADDR_WIDTH = 16,
    localparam int CW = $clog2(CORE_COUNT),
    localparam int SW = $clog2(SLOT_COUNT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CW-1:0]                slot_addr_wr_core,
    input  logic [SW-1:0]                slot_addr_wr_no,
    input  logic [ADDR_WIDTH-1:0]        slot_addr_wr_data,
    input  logic                         slot_addr_wr_valid,
    input  logic [CW-1:0]                slot_rel_core,
    input  logic [SW-1:0]                slot_rel_no,
    input  logic                         slot_rel_valid,
    output logic                         slot_rel_ready,
    input  logic [CORE_COUNT-1:0]        core_enable,
    output logic [CW-1:0]                m_desc_core,
    output logic [SW-1:0]                m_desc_slot,
    output logic [ADDR_WIDTH-1:0]        m_desc_addr,
    output logic                         m_desc_valid,
    input  logic                         m_desc_ready,
    output logic [CORE_COUNT*(SW+1)-1:0] free_count,
    output logic                         rel_err
);

    localparam int FW   = SW + 1;
    localparam int CMAX = 1 << CW;
    localparam int TBLN = CORE_COUNT * SLOT_COUNT;

    logic [SLOT_COUNT-1:0]        bitmap_q [CORE_COUNT];
    logic [SLOT_COUNT-1:0]        bitmap_d [CORE_COUNT];
    logic [ADDR_WIDTH-1:0]        table_q  [TBLN];
    logic [ADDR_WIDTH-1:0]        table_d  [TBLN];
    logic [CW-1:0]                rr_q, rr_d;
    logic                         desc_valid_q, desc_valid_d;
    logic [CW-1:0]                desc_core_q, desc_core_d;
    logic [SW-1:0]                desc_slot_q, desc_slot_d;
    logic [ADDR_WIDTH-1:0]        desc_addr_q, desc_addr_d;
    logic [CORE_COUNT*FW-1:0]     free_count_q, free_count_d;
    logic                         rel_err_q, rel_err_d;

    logic [CMAX-1:0]              core_ok;
    logic                         wr_en;
    logic                         wr_same;
    logic                         rel_core_ok;
    logic                         rel_free;
    logic                         rel_legal;
    logic                         load;
    logic                         found;
    logic [CW-1:0]                win;
    logic [SW-1:0]                pick;
    logic [SLOT_COUNT-1:0]        sel_map;

    // Which encodable core indices actually exist (matters for non-power-of-two counts)
    always_comb begin
        core_ok = '0;
        for (int c = 0; c < CMAX; c++) begin
            core_ok[CW'(c)] = (c < CORE_COUNT);
        end
    end

    // Classify the incoming address write and release
    always_comb begin
        wr_en       = slot_addr_wr_valid && core_ok[slot_addr_wr_core];
        wr_same     = slot_addr_wr_valid
                      && (slot_addr_wr_core == slot_rel_core)
                      && (slot_addr_wr_no == slot_rel_no);
        rel_core_ok = core_ok[slot_rel_core];
        rel_free    = 1'b0;
        if (rel_core_ok) begin
            rel_free = bitmap_q[slot_rel_core][slot_rel_no];
        end
        rel_legal = slot_rel_valid && rel_core_ok && !rel_free;
        // A release racing a write to the same slot is absorbed by the write
        rel_err_d = slot_rel_valid && !wr_same && (!rel_core_ok || rel_free);
    end

    // Round-robin core pick from rr pointer, then lowest free slot in that core
    always_comb begin
        load    = !desc_valid_q || m_desc_ready;
        found   = 1'b0;
        win     = '0;
        for (int i = 0; i < CORE_COUNT; i++) begin
            int ci;
            ci = int'(rr_q) + i;
            if (ci >= CORE_COUNT) begin
                ci = ci - CORE_COUNT;
            end
            if (!found && core_enable[CW'(ci)] && (|bitmap_q[CW'(ci)])) begin
                found = 1'b1;
                win   = CW'(ci);
            end
        end
        sel_map = bitmap_q[win];
        pick    = '0;
        for (int s = SLOT_COUNT - 1; s >= 0; s--) begin
            if (sel_map[SW'(s)]) begin
                pick = SW'(s);
            end
        end
    end

    // Next-state for bitmaps, address table, output register and rr pointer
    always_comb begin
        bitmap_d     = bitmap_q;
        table_d      = table_q;
        rr_d         = rr_q;
        desc_valid_d = desc_valid_q;
        desc_core_d  = desc_core_q;
        desc_slot_d  = desc_slot_q;
        desc_addr_d  = desc_addr_q;
        if (load) begin
            desc_valid_d = found;
            if (found) begin
                bitmap_d[win][pick] = 1'b0;
                desc_core_d = win;
                desc_slot_d = pick;
                desc_addr_d = table_q[{win, pick}];
                if (int'(win) == CORE_COUNT - 1) begin
                    rr_d = '0;
                end else begin
                    rr_d = win + CW'(1);
                end
            end
        end
        if (rel_legal) begin
            bitmap_d[slot_rel_core][slot_rel_no] = 1'b1;
        end
        if (wr_en) begin
            bitmap_d[slot_addr_wr_core][slot_addr_wr_no] = 1'b1;
            table_d[{slot_addr_wr_core, slot_addr_wr_no}] = slot_addr_wr_data;
        end
    end

    // Per-core popcount of the next bitmap so the count tracks the bitmap register
    always_comb begin
        free_count_d = '0;
        for (int c = 0; c < CORE_COUNT; c++) begin
            logic [FW-1:0] cnt;
            cnt = '0;
            for (int s = 0; s < SLOT_COUNT; s++) begin
                cnt = cnt + FW'(bitmap_d[CW'(c)][SW'(s)]);
            end
            free_count_d[c*FW +: FW] = cnt;
        end
    end

    // State registers; reset wipes all free state and any held descriptor
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CORE_COUNT; c++) begin
                bitmap_q[c] <= '0;
            end
            for (int i = 0; i < TBLN; i++) begin
                table_q[i] <= '0;
            end
            rr_q         <= '0;
            desc_valid_q <= 1'b0;
            desc_core_q  <= '0;
            desc_slot_q  <= '0;
            desc_addr_q  <= '0;
            free_count_q <= '0;
            rel_err_q    <= 1'b0;
        end else begin
            bitmap_q     <= bitmap_d;
            table_q      <= table_d;
            rr_q         <= rr_d;
            desc_valid_q <= desc_valid_d;
            desc_core_q  <= desc_core_d;
            desc_slot_q  <= desc_slot_d;
            desc_addr_q  <= desc_addr_d;
            free_count_q <= free_count_d;
            rel_err_q    <= rel_err_d;
        end
    end

    assign slot_rel_ready = ~rst;
    assign m_desc_valid   = desc_valid_q;
    assign m_desc_core    = desc_core_q;
    assign m_desc_slot    = desc_slot_q;
    assign m_desc_addr    = desc_addr_q;
    assign free_count     = free_count_q;
    assign rel_err        = rel_err_q;

endmodule

// File: tb/tb_slot_desc_mgr.sv
// Directed table-driven bench for slot_desc_mgr (4 cores x 16 slots).
module tb_slot_desc_mgr;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wr_core;
    logic [3:0]  wr_no;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic [1:0]  rel_core;
    logic [3:0]  rel_no;
    logic        rel_valid;
    logic        rel_ready;
    logic [3:0]  core_enable;
    logic [1:0]  d_core;
    logic [3:0]  d_slot;
    logic [15:0] d_addr;
    logic        d_valid;
    logic        d_ready;
    logic [19:0] free_count;
    logic        rel_err;

    always #5 clk = ~clk;

    slot_desc_mgr #(
        .CORE_COUNT(4),
        .SLOT_COUNT(16),
        .ADDR_WIDTH(16)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .slot_addr_wr_core (wr_core),
        .slot_addr_wr_no   (wr_no),
        .slot_addr_wr_data (wr_data),
        .slot_addr_wr_valid(wr_valid),
        .slot_rel_core     (rel_core),
        .slot_rel_no       (rel_no),
        .slot_rel_valid    (rel_valid),
        .slot_rel_ready    (rel_ready),
        .core_enable       (core_enable),
        .m_desc_core       (d_core),
        .m_desc_slot       (d_slot),
        .m_desc_addr       (d_addr),
        .m_desc_valid      (d_valid),
        .m_desc_ready      (d_ready),
        .free_count        (free_count),
        .rel_err           (rel_err)
    );

    typedef struct {
        logic        r;
        logic        wv;
        logic [1:0]  wc;
        logic [3:0]  wn;
        logic [15:0] wd;
        logic        rv;
        logic [1:0]  rc;
        logic [3:0]  rn;
        logic [3:0]  en;
        logic        rdy;
        logic        ev;
        logic [1:0]  ec;
        logic [3:0]  es;
        logic [15:0] ea;
        logic [19:0] efc;
        logic        eerr;
    } vec_t;

    vec_t tbl[$];
    vec_t tbl2[$];
    int total = 0;
    int bad = 0;

    function automatic vec_t V(
        input logic r, input logic wv, input logic [1:0] wc,
        input logic [3:0] wn, input logic [15:0] wd, input logic rv,
        input logic [1:0] rc, input logic [3:0] rn, input logic [3:0] en,
        input logic rdy, input logic ev, input logic [1:0] ec,
        input logic [3:0] es, input logic [15:0] ea, input logic [19:0] efc,
        input logic eerr);
        vec_t v;
        v.r = r; v.wv = wv; v.wc = wc; v.wn = wn; v.wd = wd;
        v.rv = rv; v.rc = rc; v.rn = rn; v.en = en; v.rdy = rdy;
        v.ev = ev; v.ec = ec; v.es = es; v.ea = ea; v.efc = efc;
        v.eerr = eerr;
        return v;
    endfunction

    function automatic vec_t W(
        input logic [1:0] c, input logic [3:0] n, input logic [15:0] d,
        input logic [3:0] en, input logic rdy, input logic ev,
        input logic [1:0] ec, input logic [3:0] es, input logic [15:0] ea,
        input logic [19:0] efc);
        return V(0, 1, c, n, d, 0, 0, 0, en, rdy, ev, ec, es, ea, efc, 0);
    endfunction

    function automatic vec_t I(
        input logic [3:0] en, input logic rdy, input logic ev,
        input logic [1:0] ec, input logic [3:0] es, input logic [15:0] ea,
        input logic [19:0] efc);
        return V(0, 0, 0, 0, 0, 0, 0, 0, en, rdy, ev, ec, es, ea, efc, 0);
    endfunction

    function automatic vec_t R(
        input logic [1:0] c, input logic [3:0] n, input logic [3:0] en,
        input logic rdy, input logic [19:0] efc, input logic eerr);
        return V(0, 0, 0, 0, 0, 1, c, n, en, rdy, 0, 0, 0, 0, efc, eerr);
    endfunction

    function automatic logic [15:0] A(input int c, input int s);
        return 16'(32'h1000 + c * 256 + s * 16);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag, input int k);
        @(negedge clk);
        rst         = v.r;
        wr_valid    = v.wv;
        wr_core     = v.wc;
        wr_no       = v.wn;
        wr_data     = v.wd;
        rel_valid   = v.rv;
        rel_core    = v.rc;
        rel_no      = v.rn;
        core_enable = v.en;
        d_ready     = v.rdy;
        @(posedge clk);
        #1;
        chk($sformatf("%s%0d.valid", tag, k), 32'(d_valid), 32'(v.ev));
        if (v.ev) begin
            chk($sformatf("%s%0d.core", tag, k), 32'(d_core), 32'(v.ec));
            chk($sformatf("%s%0d.slot", tag, k), 32'(d_slot), 32'(v.es));
            chk($sformatf("%s%0d.addr", tag, k), 32'(d_addr), 32'(v.ea));
        end
        chk($sformatf("%s%0d.free", tag, k), 32'(free_count), 32'(v.efc));
        chk($sformatf("%s%0d.err", tag, k), 32'(rel_err), 32'(v.eerr));
        chk($sformatf("%s%0d.rready", tag, k), 32'(rel_ready), 32'(!v.r));
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, ".valid"}, 32'(d_valid), 0);
        chk({nm, ".core"}, 32'(d_core), 0);
        chk({nm, ".slot"}, 32'(d_slot), 0);
        chk({nm, ".addr"}, 32'(d_addr), 0);
        chk({nm, ".free"}, 32'(free_count), 0);
        chk({nm, ".err"}, 32'(rel_err), 0);
        chk({nm, ".rready"}, 32'(rel_ready), 0);
    endtask

    initial begin
        // single slot: descriptor two cycles after write
        tbl.push_back(W(1, 3, 16'h0400, 4'hF, 1, 0, 0, 0, 0, 20'h00020));
        tbl.push_back(I(4'hF, 1, 1, 1, 3, 16'h0400, 20'h00000));
        tbl.push_back(I(4'hF, 1, 0, 0, 0, 0, 20'h00000));
        // reset, then fill slots 0..1 of every core with allocation off
        tbl.push_back(V(1, 0, 0, 0, 0, 0, 0, 0, 4'hF, 1,
                        0, 0, 0, 0, 20'h00000, 0));
        tbl.push_back(W(0, 0, A(0, 0), 4'h0, 1, 0, 0, 0, 0, 20'h00001));
        tbl.push_back(W(0, 1, A(0, 1), 4'h0, 1, 0, 0, 0, 0, 20'h00002));
        tbl.push_back(W(1, 0, A(1, 0), 4'h0, 1, 0, 0, 0, 0, 20'h00022));
        tbl.push_back(W(1, 1, A(1, 1), 4'h0, 1, 0, 0, 0, 0, 20'h00042));
        tbl.push_back(W(2, 0, A(2, 0), 4'h0, 1, 0, 0, 0, 0, 20'h00442));
        tbl.push_back(W(2, 1, A(2, 1), 4'h0, 1, 0, 0, 0, 0, 20'h00842));
        tbl.push_back(W(3, 0, A(3, 0), 4'h0, 1, 0, 0, 0, 0, 20'h08842));
        tbl.push_back(W(3, 1, A(3, 1), 4'h0, 1, 0, 0, 0, 0, 20'h10842));
        tbl.push_back(I(4'hF, 1, 1, 0, 0, A(0, 0), 20'h10841));
        tbl.push_back(I(4'hF, 1, 1, 1, 0, A(1, 0), 20'h10821));
        tbl.push_back(I(4'hF, 1, 1, 2, 0, A(2, 0), 20'h10421));
        tbl.push_back(I(4'hF, 1, 1, 3, 0, A(3, 0), 20'h08421));
        tbl.push_back(I(4'hF, 1, 1, 0, 1, A(0, 1), 20'h08420));
        tbl.push_back(I(4'hF, 1, 1, 1, 1, A(1, 1), 20'h08400));
        tbl.push_back(I(4'hF, 1, 1, 2, 1, A(2, 1), 20'h08000));
        tbl.push_back(I(4'hF, 1, 1, 3, 1, A(3, 1), 20'h00000));
        tbl.push_back(I(4'hF, 1, 0, 0, 0, 0, 20'h00000));
        // illegal / legal releases and write+release collision
        tbl.push_back(W(2, 5, 16'h2500, 4'h0, 1, 0, 0, 0, 0, 20'h00400));
        tbl.push_back(R(2, 5, 4'h0, 1, 20'h00400, 1));
        tbl.push_back(I(4'h0, 1, 0, 0, 0, 0, 20'h00400));
        tbl.push_back(R(2, 0, 4'h0, 1, 20'h00800, 0));
        tbl.push_back(I(4'h0, 1, 0, 0, 0, 0, 20'h00800));
        tbl.push_back(V(0, 1, 2, 5, 16'h2555, 1, 2, 5, 4'h0, 1,
                        0, 0, 0, 0, 20'h00800, 0));
        tbl.push_back(I(4'hF, 1, 1, 2, 0, A(2, 0), 20'h00400));
        tbl.push_back(I(4'hF, 1, 1, 2, 5, 16'h2555, 20'h00000));
        tbl.push_back(I(4'hF, 1, 0, 0, 0, 0, 20'h00000));
        // backpressure hold for 5 cycles, then single delivery
        tbl.push_back(W(0, 7, 16'h0777, 4'h0, 0, 0, 0, 0, 0, 20'h00001));
        tbl.push_back(W(1, 7, 16'h1777, 4'h0, 0, 0, 0, 0, 0, 20'h00021));
        for (int i = 0; i < 6; i++) begin
            tbl.push_back(I(4'hF, 0, 1, 0, 7, 16'h0777, 20'h00020));
        end
        tbl.push_back(I(4'hF, 1, 1, 1, 7, 16'h1777, 20'h00000));
        tbl.push_back(I(4'hF, 1, 0, 0, 0, 0, 20'h00000));
        // core 2 masked off, then re-enabled
        tbl.push_back(W(0, 9, 16'hA000, 4'h0, 1, 0, 0, 0, 0, 20'h00001));
        tbl.push_back(W(1, 9, 16'hA001, 4'h0, 1, 0, 0, 0, 0, 20'h00021));
        tbl.push_back(W(2, 9, 16'hA002, 4'h0, 1, 0, 0, 0, 0, 20'h00421));
        tbl.push_back(W(3, 9, 16'hA003, 4'h0, 1, 0, 0, 0, 0, 20'h08421));
        tbl.push_back(I(4'hB, 1, 1, 3, 9, 16'hA003, 20'h00421));
        tbl.push_back(I(4'hB, 1, 1, 0, 9, 16'hA000, 20'h00420));
        tbl.push_back(I(4'hB, 1, 1, 1, 9, 16'hA001, 20'h00400));
        tbl.push_back(I(4'hB, 1, 0, 0, 0, 0, 20'h00400));
        tbl.push_back(I(4'hB, 1, 0, 0, 0, 0, 20'h00400));
        tbl.push_back(I(4'hF, 1, 1, 2, 9, 16'hA002, 20'h00000));
        tbl.push_back(I(4'hF, 1, 0, 0, 0, 0, 20'h00000));
        // set up a held descriptor before a mid-cycle reset
        tbl.push_back(W(0, 0, 16'h0AAA, 4'h0, 1, 0, 0, 0, 0, 20'h00001));
        tbl.push_back(W(1, 0, 16'h0BBB, 4'h0, 1, 0, 0, 0, 0, 20'h00021));
        tbl.push_back(I(4'hF, 0, 1, 0, 0, 16'h0AAA, 20'h00020));
        tbl.push_back(I(4'hF, 0, 1, 0, 0, 16'h0AAA, 20'h00020));
        // after reset: nothing free; freed slot shows cleared table
        tbl2.push_back(I(4'hF, 1, 0, 0, 0, 0, 20'h00000));
        tbl2.push_back(I(4'hF, 1, 0, 0, 0, 0, 20'h00000));
        tbl2.push_back(R(0, 0, 4'hF, 1, 20'h00001, 0));
        tbl2.push_back(I(4'hF, 1, 1, 0, 0, 16'h0000, 20'h00000));
        tbl2.push_back(W(1, 0, 16'h0BEE, 4'hF, 1, 0, 0, 0, 0, 20'h00020));
        tbl2.push_back(I(4'hF, 1, 1, 1, 0, 16'h0BEE, 20'h00000));
        tbl2.push_back(I(4'hF, 1, 0, 0, 0, 0, 20'h00000));

        rst = 1'b1;
        wr_valid = 0; wr_core = 0; wr_no = 0; wr_data = 0;
        rel_valid = 0; rel_core = 0; rel_no = 0;
        core_enable = 4'hF; d_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("por");

        for (int k = 0; k < tbl.size(); k++) begin
            apply(tbl[k], "v", k);
        end

        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_reset("midrst");

        for (int k = 0; k < tbl2.size(); k++) begin
            apply(tbl2[k], "p", k);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/slot_desc_mgr.md
SLOT_DESC_MGR -- requirements
Module: slot_desc_mgr

Interface
REQ-001 Parameter CORE_COUNT, default 4: number of cores whose packet slots are managed (>=2).
REQ-002 Parameter SLOT_COUNT, default 16: slots per core (power of two, >=2).
REQ-003 Parameter ADDR_WIDTH, default 16: slot base address width.
REQ-004 Derived: CW=clog2(CORE_COUNT), SW=clog2(SLOT_COUNT).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 slot_addr_wr_core/no/data/valid  in  CW/SW/ADDR_WIDTH/1  configure a slot's base address.
REQ-008 slot_rel_core/no  in  CW/SW  slot returned by a core after processing.
REQ-009 slot_rel_valid  in  1; slot_rel_ready  out  1  release handshake.
REQ-010 core_enable  in  CORE_COUNT  per-core allocation enable mask.
REQ-011 m_desc_core/slot/addr  out  CW/SW/ADDR_WIDTH  allocated slot descriptor.
REQ-012 m_desc_valid  out  1; m_desc_ready  in  1  descriptor handshake.
REQ-013 free_count  out  CORE_COUNT*(SW+1)  free slots per core, core 0 in LSBs.
REQ-014 rel_err  out  1  one-cycle pulse on an illegal release.

Function
REQ-015 State: per-core free bitmap (SLOT_COUNT bits), address table (CORE_COUNT*SLOT_COUNT entries), round-robin pointer rr_ptr (CW bits), one-entry descriptor output register.
REQ-016 slot_addr_wr_valid: table entry written and free bit set at the next edge; write to an already-free slot only updates address; a write to a slot currently allocated re-frees it (software contract: configure only idle slots).
REQ-017 slot_rel_ready SHALL be 1 whenever rst is low; a release completes in the cycle valid is high.
REQ-018 Legal release (slot bit clear, core < CORE_COUNT): free bit set at next edge.
REQ-019 Illegal release (slot already free, or core >= CORE_COUNT): bitmap unchanged, rel_err=1 the next cycle only.
REQ-020 Address write and release of the same slot in one cycle: slot freed once, new address stored, no rel_err.
REQ-021 Load condition: output register empty, or m_desc_valid && m_desc_ready this cycle.
REQ-022 On load, candidates are cores with core_enable=1 and a nonzero bitmap as registered this cycle (same-cycle releases/writes not visible); scan from rr_ptr upward with wrap-around; first candidate wins.
REQ-023 Within the winning core the lowest-index free slot is chosen; its bit clears, output register takes {core, slot, table address}, m_desc_valid=1, rr_ptr=(core+1) mod CORE_COUNT, all at the next edge.
REQ-024 No candidate at load: m_desc_valid=0 next cycle, rr_ptr unchanged.
REQ-025 While m_desc_valid=1 and m_desc_ready=0, outputs SHALL hold stable.
REQ-026 Latency: slot freed at edge N is presentable at m_desc at edge N+1 earliest; back-to-back descriptors at one per cycle while ready=1 and slots available.
REQ-027 free_count[c] = popcount of core c's bitmap, registered, consistent with bitmap same cycle; an allocated slot never counts as free.
REQ-028 Deasserting core_enable[c] stops new allocations from c; a descriptor already in the output register is still delivered.

Reset
REQ-029 During/after rst: all bitmaps 0 (no slot free until configured), table 0, rr_ptr 0, m_desc_valid 0, m_desc_* 0, free_count 0, rel_err 0, slot_rel_ready 0.
REQ-030 Reset mid-operation discards any held descriptor and all free state; first descriptor after reset requires new address writes.

Verification
REQ-031 Reset, write core1 slot3 addr 0x0400, enable all, ready=1 -> desc {1,3,0x0400} valid 2 cycles after write; free_count[1] 1->0.
REQ-032 Configure slots 0..1 of all 4 cores, ready=1 -> 8 descriptors order cores 0,1,2,3,0,1,2,3, slots 0 then 1, one per cycle; then valid=0.
REQ-033 Hold ready=0 for 5 cycles with desc valid -> desc fields unchanged; ready=1 -> delivered once, no duplicate.
REQ-034 Release core2 slot5 when already free -> rel_err pulse 1 cycle, free_count[2] unchanged; legal release -> free_count[2]+1, no rel_err.
REQ-035 core_enable=4'b1011 with all cores holding free slots -> core 2 never allocated; re-enable -> core 2 served on next rr pass.
REQ-036 Assert rst while m_desc_valid=1 and slots free -> valid drops immediately, all free_count 0, no descriptor until reconfigured.
